// File: rtl/bit_serializer.sv
// bit_serializer
//
// Parallel-to-serial front end for the sequence-detector FSMs. A WIDTH-bit word
// is accepted through a load/ready handshake and shifted out MSB-first, one bit
// per clock. Words stream back-to-back with no idle gap when the next load
// lands on the final bit of the current frame.
//
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the loaded word) after the LSB, making each frame WIDTH+1 bits.
//
// Parameters:
//   WIDTH    bits per word, legal range 2..32
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   data_in  parallel word, sampled only on an accepted load
//   load     load request, accepted when load && ready
//   ready    a load will be accepted at the next edge
//   out      serial bit, 0 whenever valid is 0
//   valid    out carries a frame bit this cycle
//   last     final bit of the current frame

module bit_serializer #(
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             valid,
   output logic             last
);

`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif

   localparam int unsigned   CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             at_last;
   logic             accept;

`ifdef BIT_SERIALIZER_PARITY_EN
   localparam logic [CW-1:0] PAR_CNT = CW'(WIDTH);

   logic par_q, par_d;

   // Parity is taken from the word as loaded, since sreg is consumed by shifting.
   always_comb begin
      par_d = par_q;
      if (accept) begin
         par_d = ^data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   // ready depends on state and cnt only, so a load never feeds back into it.
   always_comb begin
      at_last = (state_q == StShift) && (cnt_q == LAST_CNT);
      ready   = (state_q == StIdle) || at_last;
      accept  = load && ready;
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      valid   = 1'b0;
      out     = 1'b0;
      last    = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               sreg_d  = data_in;
               cnt_d   = '0;
               state_d = StShift;
            end
         end

         StShift: begin
            valid = 1'b1;
            last  = at_last;
`ifdef BIT_SERIALIZER_PARITY_EN
            // After WIDTH shifts sreg is empty; the extra cycle carries parity.
            if (cnt_q == PAR_CNT) begin
               out = par_q;
            end else begin
               out = sreg_q[WIDTH-1];
            end
`else
            out = sreg_q[WIDTH-1];
`endif
            if (at_last) begin
               if (accept) begin
                  // Reload on the final bit so the next MSB follows with no gap.
                  sreg_d = data_in;
                  cnt_d  = '0;
               end else begin
                  sreg_d  = '0;
                  cnt_d   = '0;
                  state_d = StIdle;
               end
            end else begin
               sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
               cnt_d  = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//
// Self-checking bench for bit_serializer (WIDTH=7). A queue of expected serial
// bits is filled whenever a load is accepted and drained one entry per clock;
// every cycle the DUT outputs are compared against the head of that queue.
// Honours BIT_SERIALIZER_PARITY_EN in the same way as the design.

module tb_bit_serializer;

   localparam int unsigned W = 7;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] data_in = '0;
   logic         load = 1'b0;
   logic         ready;
   logic         out;
   logic         valid;
   logic         last;

   // Expected parity bit for the word currently on data_in.
   bit           cur_par = 1'b0;

   bit           exp_q[$];
   bit           acc;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;

   typedef struct {
      logic [W-1:0] data;
      bit           b2b;   // 1: load on the last bit of the previous frame
      bit           par;   // expected even-parity bit
   } vec_t;

   vec_t vecs[6];

   bit_serializer #(
      .WIDTH(W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .data_in(data_in),
      .load   (load),
      .ready  (ready),
      .out    (out),
      .valid  (valid),
      .last   (last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
      end
   endtask

   // Reference model: the expected bit stream. A load is accepted when the
   // stream is empty (idle) or holds only its final bit.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         cyc++;
         acc = load && (exp_q.size() <= 1);
         if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
         if (acc) begin
            for (int i = W - 1; i >= 0; i--) begin
               exp_q.push_back(data_in[i]);
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            exp_q.push_back(cur_par);
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", valid, exp_q.size() > 0);
      chk("out",   out,   (exp_q.size() > 0) ? exp_q[0] : 1'b0);
      chk("last",  last,  exp_q.size() == 1);
      chk("ready", ready, exp_q.size() <= 1);
   end

   task automatic wait_size(input int target, input string name);
      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == target) return;
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL %s timeout got=%0d exp=%0d", name, exp_q.size(), target);
   endtask

   task automatic do_load(input logic [W-1:0] d, input bit p);
      load    = 1'b1;
      data_in = d;
      cur_par = p;
      @(posedge clk);
      #1;
      load    = 1'b0;
      data_in = W'($urandom);
   endtask

   initial begin
      vecs[0] = '{data: 7'b1010101, b2b: 1'b0, par: 1'b0};
      vecs[1] = '{data: 7'b0000000, b2b: 1'b1, par: 1'b0};
      vecs[2] = '{data: 7'b1010100, b2b: 1'b0, par: 1'b1};
      vecs[3] = '{data: 7'b1100110, b2b: 1'b1, par: 1'b0};
      vecs[4] = '{data: 7'b1111111, b2b: 1'b1, par: 1'b1};
      vecs[5] = '{data: 7'b0000001, b2b: 1'b0, par: 1'b1};

      // Reset for 3 cycles, then idle with no load.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Table: single words from idle and back-to-back streams.
      foreach (vecs[i]) begin
         if (vecs[i].b2b) begin
            wait_size(1, "wait_last");
         end else begin
            wait_size(0, "wait_idle");
         end
         do_load(vecs[i].data, vecs[i].par);
      end
      wait_size(0, "drain");
      repeat (2) @(posedge clk);
      #1;

      // Load while busy on bit 3 must be ignored.
      do_load(7'b1010101, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      load    = 1'b1;
      data_in = 7'b1111111;
      cur_par = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_size(0, "busy_drain");
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset during bit 4.
      do_load(7'b1010101, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", valid, 1'b0);
      chk("rst_out",   out,   1'b0);
      chk("rst_last",  last,  1'b0);
      chk("rst_ready", ready, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_ready", ready, 1'b1);
      do_load(7'b0110011, 1'b0);
      wait_size(0, "post_rst_drain");
      repeat (3) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
